// File: rtl/thumb_pkg.sv
// Shared Thumb decode types: format select codes, skid FSM states and the decoded payload.
package thumb_pkg;

  typedef logic [4:0] sel_t;

  localparam sel_t SEL_INVALID       = 5'd0;
  localparam sel_t SEL_SHIFT         = 5'd1;
  localparam sel_t SEL_ADD_SUB       = 5'd2;
  localparam sel_t SEL_MOV_CMP_IMM   = 5'd3;
  localparam sel_t SEL_ALU           = 5'd4;
  localparam sel_t SEL_HI_REG_BX     = 5'd5;
  localparam sel_t SEL_PC_LDR        = 5'd6;
  localparam sel_t SEL_LDR_STR_REG   = 5'd7;
  localparam sel_t SEL_LDR_STR_SIGN  = 5'd8;
  localparam sel_t SEL_LDR_STR_IMM   = 5'd9;
  localparam sel_t SEL_LDR_STR_HALF  = 5'd10;
  localparam sel_t SEL_SP_LDR_STR    = 5'd11;
  localparam sel_t SEL_LOAD_ADDR     = 5'd12;
  localparam sel_t SEL_SP_ADJ        = 5'd13;
  localparam sel_t SEL_PUSH_POP      = 5'd14;
  localparam sel_t SEL_MULTI_LDM_STM = 5'd15;
  localparam sel_t SEL_COND_B        = 5'd16;
  localparam sel_t SEL_SWI           = 5'd17;
  localparam sel_t SEL_UNCOND_B      = 5'd18;
  localparam sel_t SEL_LONG_BL       = 5'd19;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } skid_st_t;

  // The PC tag width is a top-level parameter, so it travels beside this struct.
  typedef struct packed {
    sel_t        sel;
    logic [2:0]  rd;
    logic [2:0]  rs;
    logic [2:0]  rn;
    logic [10:0] imm;
    logic [15:0] instr;
  } dec_t;

  function automatic logic sel_is_illegal(input sel_t s);
    return s == SEL_INVALID;
  endfunction

endpackage

// File: rtl/thumb_fmt_decode.sv
// Combinational Thumb format classifier: 16-bit instruction -> format select, first match wins.
// Zero latency; no handshake, so no backpressure of its own.
module thumb_fmt_decode
  import thumb_pkg::*;
(
  input  logic [15:0] instr,
  output sel_t        sel
);

  // The low byte never takes part in format selection.
  logic unused_low;
  assign unused_low = ^instr[7:0];

  always_comb begin
    sel = SEL_INVALID;
    if (instr[15:13] == 3'b000 && instr[12:11] != 2'b11)      sel = SEL_SHIFT;
    else if (instr[15:11] == 5'b00011)                         sel = SEL_ADD_SUB;
    else if (instr[15:13] == 3'b001)                           sel = SEL_MOV_CMP_IMM;
    else if (instr[15:10] == 6'b010000)                        sel = SEL_ALU;
    else if (instr[15:10] == 6'b010001)                        sel = SEL_HI_REG_BX;
    else if (instr[15:11] == 5'b01001)                         sel = SEL_PC_LDR;
    else if (instr[15:12] == 4'b0101 && !instr[9])             sel = SEL_LDR_STR_REG;
    else if (instr[15:12] == 4'b0101)                          sel = SEL_LDR_STR_SIGN;
    else if (instr[15:13] == 3'b011)                           sel = SEL_LDR_STR_IMM;
    else if (instr[15:12] == 4'b1000)                          sel = SEL_LDR_STR_HALF;
    else if (instr[15:12] == 4'b1001)                          sel = SEL_SP_LDR_STR;
    else if (instr[15:12] == 4'b1010)                          sel = SEL_LOAD_ADDR;
    else if (instr[15:8] == 8'b10110000)                       sel = SEL_SP_ADJ;
    else if (instr[15:12] == 4'b1011 && instr[10:9] == 2'b10)  sel = SEL_PUSH_POP;
    else if (instr[15:12] == 4'b1100)                          sel = SEL_MULTI_LDM_STM;
    else if (instr[15:12] == 4'b1101 && instr[11:9] != 3'b111) sel = SEL_COND_B;
    else if (instr[15:8] == 8'b11011111)                       sel = SEL_SWI;
    else if (instr[15:11] == 5'b11100)                         sel = SEL_UNCOND_B;
    else if (instr[15:12] == 4'b1111)                          sel = SEL_LONG_BL;
  end

endmodule

// File: rtl/thumb_decode_stage.sv
// Thumb decode slice: classify + field-extract, 2-entry skid (main + skid register), illegal counter.
// Latency: accept edge == out_valid edge. Backpressure: registered in_ready drops once both entries hold data.
module thumb_decode_stage
  import thumb_pkg::*;
#(
  parameter int PC_W  = 32,
  parameter int SEL_W = 5,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_instr,
  input  logic [PC_W-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SEL_W-1:0] out_sel,
  output logic [2:0]       out_rd,
  output logic [2:0]       out_rs,
  output logic [2:0]       out_rn,
  output logic [10:0]      out_imm,
  output logic [15:0]      out_instr,
  output logic [PC_W-1:0]  out_pc,
  output logic             out_illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  skid_st_t        state_q, state_d;
  logic            in_ready_q;
  sel_t            in_sel;
  dec_t            in_dec, main_q, skid_q;
  logic [PC_W-1:0] main_pc_q, skid_pc_q;
  logic [CNT_W-1:0] cnt_q;
  logic            accept, consume;
  logic            ld_main_in, ld_main_skid, ld_skid;

  thumb_fmt_decode u_fmt (
    .instr (in_instr),
    .sel   (in_sel)
  );

  assign in_dec = '{sel: in_sel, rd: in_instr[2:0], rs: in_instr[5:3], rn: in_instr[8:6],
                    imm: in_instr[10:0], instr: in_instr};

  assign out_valid = (state_q != ST_EMPTY);
  assign accept    = in_valid & in_ready_q;
  assign consume   = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != ST_TWO);
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: if (accept) state_d = ST_ONE;
        ST_ONE: begin
          if (accept && !consume)      state_d = ST_TWO;
          else if (!accept && consume) state_d = ST_EMPTY;
        end
        ST_TWO:   if (consume) state_d = ST_ONE;
        default:  state_d = ST_EMPTY;
      endcase
    end
  end

  // Flush suppresses every load; the payload is don't-care once the buffer is empty.
  always_comb begin
    ld_main_in   = 1'b0;
    ld_main_skid = 1'b0;
    ld_skid      = 1'b0;
    if (!flush) begin
      case (state_q)
        ST_EMPTY: ld_main_in = accept;
        ST_ONE: begin
          ld_main_in = accept & consume;
          ld_skid    = accept & ~consume;
        end
        ST_TWO:   ld_main_skid = consume;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_q    <= '0;
      main_pc_q <= '0;
      skid_q    <= '0;
      skid_pc_q <= '0;
    end else begin
      if (ld_main_in) begin
        main_q    <= in_dec;
        main_pc_q <= in_pc;
      end else if (ld_main_skid) begin
        main_q    <= skid_q;
        main_pc_q <= skid_pc_q;
      end
      if (ld_skid) begin
        skid_q    <= in_dec;
        skid_pc_q <= in_pc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (accept && !flush && sel_is_illegal(in_sel) && cnt_q != '1) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign in_ready    = in_ready_q;
  assign out_sel     = SEL_W'(main_q.sel);
  assign out_rd      = main_q.rd;
  assign out_rs      = main_q.rs;
  assign out_rn      = main_q.rn;
  assign out_imm     = main_q.imm;
  assign out_instr   = main_q.instr;
  assign out_pc      = main_pc_q;
  assign out_illegal = sel_is_illegal(main_q.sel);
  assign illegal_cnt = cnt_q;

endmodule
